// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - op_class codes and state encoding shared by the sequencer
package cpu_ctrl_pkg;

    localparam logic [2:0] OP_ALU    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_STORE  = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_JUMP   = 3'd4;
    localparam logic [2:0] OP_HALT   = 3'd5;
    localparam logic [2:0] OP_NOP    = 3'd6;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;
    localparam logic [2:0] ST_FAULT  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_MEM    = ST_MEM,
        S_WB     = ST_WB,
        S_HALT   = ST_HALT,
        S_FAULT  = ST_FAULT
    } state_e;

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - memory handshake wait counter, expires at TIMEOUT-1
module wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count;

    // Saturates at LAST so a held expire never wraps back to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-cycle fetch/decode/exec/mem/writeback control FSM
module pc_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op_class,
    input  logic       branch_taken,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       ir_load,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       rf_write,
    output logic       pc_write,
    output logic       branch,
    output logic       jump,
    output logic       halted,
    output logic       fault
);

    state_e     state;
    state_e     state_next;
    logic [2:0] op_reg;
    logic       req_active;
    logic       req_ack;
    logic       timer_expire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg <= OP_NOP;
        end else if (state == S_DECODE) begin
            op_reg <= op_class;
        end
    end

    // One timer serves both handshakes; it idles at zero outside FETCH/MEM.
    wait_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!req_active || req_ack),
        .enable (req_active && !req_ack),
        .expire (timer_expire)
    );

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;
        req_active = 1'b0;
        req_ack    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req   = 1'b1;
                req_active = 1'b1;
                req_ack    = imem_ack;
                if (imem_ack) begin
                    ir_load    = 1'b1;
                    state_next = S_DECODE;
                end else if (timer_expire) begin
                    state_next = S_FAULT;
                end
            end
            S_DECODE: begin
                state_next = S_EXEC;
            end
            S_EXEC: begin
                case (op_reg)
                    OP_ALU:   state_next = S_WB;
                    OP_LOAD,
                    OP_STORE: state_next = S_MEM;
                    OP_BRANCH: begin
                        pc_write   = 1'b1;
                        branch     = branch_taken;
                        state_next = S_FETCH;
                    end
                    OP_JUMP: begin
                        pc_write   = 1'b1;
                        jump       = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_HALT:  state_next = S_HALT;
                    default: begin
                        pc_write   = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req   = 1'b1;
                dmem_we    = (op_reg == OP_STORE);
                req_active = 1'b1;
                req_ack    = dmem_ack;
                if (dmem_ack) begin
                    if (op_reg == OP_STORE) begin
                        pc_write   = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (timer_expire) begin
                    state_next = S_FAULT;
                end
            end
            S_WB: begin
                rf_write   = 1'b1;
                pc_write   = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer against a per-instruction trace model
module tb_pc_sequencer;

    localparam int TIMEOUT = 16;

    localparam logic [9:0] M_IREQ = 10'b10_0000_0000;
    localparam logic [9:0] M_IRL  = 10'b01_0000_0000;
    localparam logic [9:0] M_DREQ = 10'b00_1000_0000;
    localparam logic [9:0] M_DWE  = 10'b00_0100_0000;
    localparam logic [9:0] M_RFW  = 10'b00_0010_0000;
    localparam logic [9:0] M_PCW  = 10'b00_0001_0000;
    localparam logic [9:0] M_BR   = 10'b00_0000_1000;
    localparam logic [9:0] M_JMP  = 10'b00_0000_0100;
    localparam logic [9:0] M_HLT  = 10'b00_0000_0010;
    localparam logic [9:0] M_FLT  = 10'b00_0000_0001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op_class = 3'd0;
    logic       branch_taken = 1'b0;
    logic       imem_ack = 1'b0;
    logic       dmem_ack = 1'b0;
    logic       imem_req, ir_load, dmem_req, dmem_we, rf_write;
    logic       pc_write, branch, jump, halted, fault;
    logic [9:0] outs;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       start;
        logic [2:0] opc;
        logic       bt;
        logic       iack;
        logic       dack;
        logic [9:0] exp;
    } cyc_t;

    cyc_t plan[$];

    always #5 clk = ~clk;

    pc_sequencer #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op_class     (op_class),
        .branch_taken (branch_taken),
        .imem_ack     (imem_ack),
        .dmem_ack     (dmem_ack),
        .imem_req     (imem_req),
        .ir_load      (ir_load),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .rf_write     (rf_write),
        .pc_write     (pc_write),
        .branch       (branch),
        .jump         (jump),
        .halted       (halted),
        .fault        (fault)
    );

    assign outs = {imem_req, ir_load, dmem_req, dmem_we, rf_write,
                   pc_write, branch, jump, halted, fault};

    // Inputs that should not matter in a given cycle are randomized.
    function automatic cyc_t rnd_cyc(input logic [9:0] exp);
        cyc_t c;
        c.start = 1'($urandom);
        c.opc   = 3'($urandom);
        c.bt    = 1'($urandom);
        c.iack  = 1'($urandom);
        c.dack  = 1'($urandom);
        c.exp   = exp;
        return c;
    endfunction

    function automatic void add_start();
        cyc_t c;
        c = rnd_cyc('0);
        c.start = 1'b1;
        plan.push_back(c);
    endfunction

    function automatic void add_hold(input logic [9:0] exp, input int n);
        for (int k = 0; k < n; k++) plan.push_back(rnd_cyc(exp));
    endfunction

    // One instruction: iw/dw are wait cycles before ack; >= TIMEOUT means never acked.
    function automatic void add_instr(input logic [2:0] op, input logic bt, input int iw, input int dw);
        cyc_t c;
        for (int k = 0; k <= iw && k < TIMEOUT; k++) begin
            c = rnd_cyc(M_IREQ);
            c.iack = (k == iw);
            if (k == iw) c.exp = c.exp | M_IRL;
            plan.push_back(c);
        end
        if (iw >= TIMEOUT) return;
        c = rnd_cyc('0);
        c.opc = op;
        plan.push_back(c);
        c = rnd_cyc('0);
        c.bt = bt;
        case (op)
            3'd3:       c.exp = M_PCW | (bt ? M_BR : 10'b0);
            3'd4:       c.exp = M_PCW | M_JMP;
            3'd6, 3'd7: c.exp = M_PCW;
            default:    c.exp = '0;
        endcase
        plan.push_back(c);
        if (op == 3'd1 || op == 3'd2) begin
            for (int k = 0; k <= dw && k < TIMEOUT; k++) begin
                c = rnd_cyc(M_DREQ | ((op == 3'd2) ? M_DWE : 10'b0));
                c.dack = (k == dw);
                if (k == dw && op == 3'd2) c.exp = c.exp | M_PCW;
                plan.push_back(c);
            end
        end
        if (op == 3'd0 || (op == 3'd1 && dw < TIMEOUT)) plan.push_back(rnd_cyc(M_RFW | M_PCW));
    endfunction

    task automatic drive(input cyc_t c);
        @(posedge clk);
        #1;
        start        = c.start;
        op_class     = c.opc;
        branch_taken = c.bt;
        imem_ack     = c.iack;
        dmem_ack     = c.dack;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        cyc_t c;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (outs !== 10'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %b expected %b", i, outs, 10'b0);
            end
        end
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            c = rnd_cyc('0);
            c.start = 1'b0;
            drive(c);
            checks++;
            if (outs !== 10'b0) begin
                errors++;
                $display("FAIL idle_no_start cycle %0d: got %b expected %b", i, outs, 10'b0);
            end
        end
    endtask

    task automatic test_alu();
        plan.delete();
        add_start();
        repeat (3) add_instr(3'd0, 1'b0, 0, 0);
        foreach (plan[i]) begin
            drive(plan[i]);
            checks++;
            if (outs !== plan[i].exp) begin
                errors++;
                $display("FAIL alu cycle %0d: got %b expected %b", i, outs, plan[i].exp);
            end
        end
        apply_reset();
    endtask

    task automatic test_branch();
        plan.delete();
        add_start();
        add_instr(3'd3, 1'b1, 0, 0);
        add_instr(3'd3, 1'b0, 0, 0);
        add_instr(3'd4, 1'b0, 0, 0);
        add_instr(3'd6, 1'b1, 0, 0);
        add_instr(3'd7, 1'b1, 0, 0);
        foreach (plan[i]) begin
            drive(plan[i]);
            checks++;
            if (outs !== plan[i].exp) begin
                errors++;
                $display("FAIL branch_jump cycle %0d: got %b expected %b", i, outs, plan[i].exp);
            end
        end
        apply_reset();
    endtask

    task automatic test_mem_wait();
        plan.delete();
        add_start();
        add_instr(3'd1, 1'b0, 0, 3);
        add_instr(3'd2, 1'b0, 1, 2);
        add_instr(3'd2, 1'b0, 0, 0);
        add_instr(3'd1, 1'b0, 0, 0);
        foreach (plan[i]) begin
            drive(plan[i]);
            checks++;
            if (outs !== plan[i].exp) begin
                errors++;
                $display("FAIL mem_wait cycle %0d: got %b expected %b", i, outs, plan[i].exp);
            end
        end
        apply_reset();
    endtask

    task automatic test_random();
        logic [2:0] ops [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
        int iw, dw;
        plan.delete();
        add_start();
        for (int n = 0; n < 30; n++) begin
            iw = ($urandom_range(3) == 0) ? $urandom_range(TIMEOUT - 1) : $urandom_range(1);
            dw = ($urandom_range(3) == 0) ? $urandom_range(TIMEOUT - 1) : $urandom_range(1);
            add_instr(ops[$urandom_range(6)], 1'($urandom), iw, dw);
        end
        foreach (plan[i]) begin
            drive(plan[i]);
            checks++;
            if (outs !== plan[i].exp) begin
                errors++;
                $display("FAIL random cycle %0d: got %b expected %b", i, outs, plan[i].exp);
            end
        end
        apply_reset();
    endtask

    task automatic test_timeout();
        plan.delete();
        add_start();
        add_instr(3'd0, 1'b0, TIMEOUT, 0);
        add_hold(M_FLT, 5);
        foreach (plan[i]) begin
            drive(plan[i]);
            checks++;
            if (outs !== plan[i].exp) begin
                errors++;
                $display("FAIL imem_timeout cycle %0d: got %b expected %b", i, outs, plan[i].exp);
            end
        end
        apply_reset();
        plan.delete();
        add_start();
        add_instr(3'd0, 1'b0, TIMEOUT - 1, 0);
        add_instr(3'd2, 1'b0, 0, TIMEOUT - 1);
        add_instr(3'd1, 1'b0, 0, TIMEOUT);
        add_hold(M_FLT, 5);
        foreach (plan[i]) begin
            drive(plan[i]);
            checks++;
            if (outs !== plan[i].exp) begin
                errors++;
                $display("FAIL last_cycle_ack_and_dmem_timeout cycle %0d: got %b expected %b", i, outs, plan[i].exp);
            end
        end
        apply_reset();
    endtask

    task automatic test_halt();
        cyc_t c;
        plan.delete();
        add_start();
        add_instr(3'd0, 1'b0, 0, 0);
        add_instr(3'd5, 1'b0, 1, 0);
        add_hold(M_HLT, 8);
        foreach (plan[i]) begin
            drive(plan[i]);
            checks++;
            if (outs !== plan[i].exp) begin
                errors++;
                $display("FAIL halt cycle %0d: got %b expected %b", i, outs, plan[i].exp);
            end
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (outs !== 10'b0) begin
            errors++;
            $display("FAIL halt_async_reset: got %b expected %b", outs, 10'b0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        start = 1'b0;
        c = rnd_cyc('0);
        c.start = 1'b0;
        drive(c);
        checks++;
        if (outs !== 10'b0) begin
            errors++;
            $display("FAIL halt_reset_idle: got %b expected %b", outs, 10'b0);
        end
    endtask

    task automatic test_reset_mid_mem();
        cyc_t c;
        apply_reset();
        plan.delete();
        add_start();
        add_instr(3'd1, 1'b0, 0, 10);
        for (int i = 0; i < 7; i++) begin
            drive(plan[i]);
            checks++;
            if (outs !== plan[i].exp) begin
                errors++;
                $display("FAIL mid_mem cycle %0d: got %b expected %b", i, outs, plan[i].exp);
            end
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (outs !== 10'b0) begin
            errors++;
            $display("FAIL mid_mem_async_reset: got %b expected %b", outs, 10'b0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            c = rnd_cyc('0);
            c.start = 1'b0;
            drive(c);
            checks++;
            if (outs !== 10'b0) begin
                errors++;
                $display("FAIL mid_mem_idle cycle %0d: got %b expected %b", i, outs, 10'b0);
            end
        end
        plan.delete();
        add_start();
        add_instr(3'd2, 1'b0, 0, 1);
        add_instr(3'd0, 1'b0, 0, 0);
        foreach (plan[i]) begin
            drive(plan[i]);
            checks++;
            if (outs !== plan[i].exp) begin
                errors++;
                $display("FAIL after_reset cycle %0d: got %b expected %b", i, outs, plan[i].exp);
            end
        end
    endtask

    initial begin
        test_reset();
        apply_reset();
        test_alu();
        test_branch();
        test_mem_wait();
        test_random();
        test_timeout();
        test_halt();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
